// File: rtl/lc4_cla_pkg.sv
// Shared definitions for the pipelined LC4 carry-lookahead adder/subtractor:
// operation encodings, the per-stage tag and operand-conditioning helpers.
package lc4_cla_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Control that travels alongside each operand slot through the pipe.
  typedef struct packed {
    logic [1:0] op;
    logic       sat;
    logic       valid;
  } stage_tag_t;

  // SUB and SBB both add the one's complement of B.
  function automatic logic op_inv_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  function automatic logic op_cin(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lc4_cla_if.sv
// Operand and result channels of lc4_cla_pipe bundled as one interface.
interface lc4_cla_if #(
  parameter int WIDTH = 32
);

  // Both channels use valid/ready: a beat transfers on a rising clk edge where
  // valid and ready are both high; valid and its payload must stay stable until
  // that transfer, and ready may be asserted independently of valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             in_sat;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

endinterface

// File: rtl/lc4_cla_seg.sv
// Combinational SEG_W-bit carry-lookahead segment: per-bit generate/propagate,
// 4-bit group generate/propagate, and carries resolved from the group carries.
module lc4_cla_seg #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int NGRP = SEG_W / 4;

  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] p;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;
  logic [SEG_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    grp_c[0] = cin;
    for (int j = 0; j < NGRP; j++) begin
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_p[j] = &p[4*j +: 4];
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end
    // Bit carries inside each group depend only on that group's carry-in.
    for (int j = 0; j < NGRP; j++) begin
      c[4*j]   = grp_c[j];
      c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & grp_c[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & grp_c[j]);
    end
    c[SEG_W] = grp_c[NGRP];
  end

  assign sum      = p ^ c[SEG_W-1:0];
  assign cout     = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/lc4_cla_pipe.sv
// Pipelined WIDTH-bit add/subtract: one SEG_W CLA segment per register stage,
// carry rippling stage to stage. Optional signed saturation: LC4_CLA_SAT_EN.
module lc4_cla_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input logic      clk,
  input logic      rst,
  lc4_cla_if.slave bus
);

  import lc4_cla_pkg::*;

  localparam int NSEG = WIDTH / SEG_W;
  localparam int LAST = NSEG - 1;

  // The whole pipe advances together; a stalled output freezes every stage.
  logic en;
  assign en           = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  logic [WIDTH-1:0] in_b_eff;
  logic             in_cin_eff;
  stage_tag_t       in_tag;

  assign in_b_eff   = op_inv_b(bus.in_op) ? ~bus.in_b : bus.in_b;
  assign in_cin_eff = op_cin(bus.in_op, bus.in_cin);

`ifdef LC4_CLA_SAT_EN
  assign in_tag = {bus.in_op, bus.in_sat, bus.in_valid};
`else
  assign in_tag = {bus.in_op, 1'b0, bus.in_valid};
`endif

  // Stages 0..LAST-1: each keeps only the operand bits still to be added and
  // the sum bits already finished below them.
  for (genvar k = 0; k < LAST; k++) begin : stg
    localparam int LO = k * SEG_W;
    localparam int RW = WIDTH - LO;

    logic [RW-1:0]       s_a;
    logic [RW-1:0]       s_b;
    logic                s_c;
    stage_tag_t          s_tag;
    logic [SEG_W-1:0]    seg_sum;
    logic                seg_cout;
    logic                unused_cmsb;
    logic [LO+SEG_W-1:0] n_sum;

    logic [RW-SEG_W-1:0] a_q;
    logic [RW-SEG_W-1:0] b_q;
    logic [LO+SEG_W-1:0] sum_q;
    logic                c_q;
    stage_tag_t          tag_q;

    if (k == 0) begin : src_in
      assign s_a   = bus.in_a;
      assign s_b   = in_b_eff;
      assign s_c   = in_cin_eff;
      assign s_tag = in_tag;
      assign n_sum = seg_sum;
    end else begin : src_prev
      assign s_a   = stg[k-1].a_q;
      assign s_b   = stg[k-1].b_q;
      assign s_c   = stg[k-1].c_q;
      assign s_tag = stg[k-1].tag_q;
      assign n_sum = {seg_sum, stg[k-1].sum_q};
    end

    lc4_cla_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a        (s_a[SEG_W-1:0]),
      .b        (s_b[SEG_W-1:0]),
      .cin      (s_c),
      .sum      (seg_sum),
      .cout     (seg_cout),
      .c_msb_in (unused_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q   <= '0;
        b_q   <= '0;
        sum_q <= '0;
        c_q   <= 1'b0;
        tag_q <= '0;
      end else if (en) begin
        a_q   <= s_a[RW-1:SEG_W];
        b_q   <= s_b[RW-1:SEG_W];
        sum_q <= n_sum;
        c_q   <= seg_cout;
        tag_q <= s_tag;
      end
    end
  end

  // Final segment feeds the output register together with the flags.
  logic [SEG_W-1:0] f_a;
  logic [SEG_W-1:0] f_b;
  logic             f_c;
  stage_tag_t       f_tag;
  logic [SEG_W-1:0] f_sum;
  logic             f_cout;
  logic             f_cmsb;
  logic [WIDTH-1:0] raw_sum;

  if (LAST == 0) begin : fin_in
    assign f_a     = bus.in_a;
    assign f_b     = in_b_eff;
    assign f_c     = in_cin_eff;
    assign f_tag   = in_tag;
    assign raw_sum = f_sum;
  end else begin : fin_prev
    assign f_a     = stg[LAST-1].a_q;
    assign f_b     = stg[LAST-1].b_q;
    assign f_c     = stg[LAST-1].c_q;
    assign f_tag   = stg[LAST-1].tag_q;
    assign raw_sum = {f_sum, stg[LAST-1].sum_q};
  end

  lc4_cla_seg #(
    .SEG_W (SEG_W)
  ) u_seg_last (
    .a        (f_a),
    .b        (f_b),
    .cin      (f_c),
    .sum      (f_sum),
    .cout     (f_cout),
    .c_msb_in (f_cmsb)
  );

  logic             raw_ovf;
  logic [WIDTH-1:0] res;

  assign raw_ovf = f_cmsb ^ f_cout;

`ifdef LC4_CLA_SAT_EN
  logic sat_hit;
  // On overflow the raw sign bit is inverted, so it selects the clamp direction.
  assign sat_hit = f_tag.sat & raw_ovf & ((f_tag.op == OP_ADD) | (f_tag.op == OP_SUB));
  assign res     = sat_hit ? {~raw_sum[WIDTH-1], {(WIDTH-1){raw_sum[WIDTH-1]}}} : raw_sum;
`else
  logic unused_sat;
  assign unused_sat = ^{f_tag.op, f_tag.sat, bus.in_sat};
  assign res        = raw_sum;
`endif

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (en) begin
      out_valid_q <= f_tag.valid;
      out_sum_q   <= res;
      out_cout_q  <= f_cout;
      out_ovf_q   <= raw_ovf;
      out_zero_q  <= (res == '0);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_zero  = out_zero_q;

endmodule
